if_fetch_stage: RTL and testbench

Instruction fetch stage of the RV64 pipelined core. It owns the program counter and issues word-aligned fetch requests to instruction memory over a valid/ready request channel. It collects in-order responses into a small skid FIFO and presents {instruction, PC} to the IF/ID boundary, where the instruction word feeds decode and immediate generation. It also accepts branch/jump redirects from execute and discards wrong-path fetches.

---
 rtl/if_fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word-aligned fetch requests,
// collects in-order responses into a skid FIFO and hands {instr, pc} to decode.
// Redirects from execute flush the FIFO and kill responses still owed for
// wrong-path requests.

// Simulation-only invariants of the fetch stage.
module if_fetch_stage_checker #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic [CW-1:0] fifo_count,
  input logic [CW-1:0] inflight,
  input logic [1:0]    pc_low
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // The credit scheme must keep the FIFO from ever being written while full.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (fifo_count == FULL)))
    else $error("if_fetch_stage: write into a full skid FIFO");

  // Outstanding requests can never exceed the FIFO capacity.
  a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
    inflight <= FULL)
    else $error("if_fetch_stage: outstanding requests exceed capacity");

  // Fetch addresses stay word aligned.
  a_pc_aligned: assert property (@(posedge clk) disable iff (reset)
    pc_low == 2'b00)
    else $error("if_fetch_stage: misaligned fetch address");
endmodule

module if_fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK   = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE      = CW'(1'b1);
  localparam logic [AW-1:0]   PTR_ONE      = AW'(1'b1);

  // Architectural state
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   kill;
  logic [CW-1:0]   fifo_count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [31:0]     fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];

  // Combinational control
  logic [CW:0]     credit_sum;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [CW-1:0]   inflight_next;
  logic [XLEN-1:0] redirect_target;

  // Request credit, response disposition and IF/ID presentation.
  always_comb begin
    credit_sum      = {1'b0, inflight} + {1'b0, fifo_count};
    // Killed-but-outstanding requests still hold credit: their responses
    // have not arrived yet, so they still occupy the response path.
    imem_req_valid  = !reset && !redirect_valid && (credit_sum < CREDIT_LIMIT);
    imem_req_addr   = pc;
    req_fire        = imem_req_valid && imem_req_ready;
    inflight_next   = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
    // A response is kept only when no redirect is flushing this cycle and it
    // does not belong to a wrong-path request.
    push            = imem_rsp_valid && !redirect_valid && (kill == {CW{1'b0}});
    id_valid        = (fifo_count != {CW{1'b0}}) && !redirect_valid;
    pop             = id_valid && id_ready;
    id_instr        = fifo_instr[rd_ptr];
    id_pc           = fifo_pc[rd_ptr];
    redirect_target = redirect_pc & ALIGN_MASK;
  end

  // Fetch PC and the PC expected for the next kept response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc     <= redirect_target;
      rsp_pc <= redirect_target;
    end else begin
      if (req_fire) begin
        pc <= pc + PC_STEP;
      end
      if (push) begin
        rsp_pc <= rsp_pc + PC_STEP;
      end
    end
  end

  // Outstanding request count and number of wrong-path responses to discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= {CW{1'b0}};
      kill     <= {CW{1'b0}};
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        // Everything still owed after this cycle is from the old path,
        // including anything a previous redirect had already marked.
        kill <= inflight_next;
      end else if (imem_rsp_valid && (kill != {CW{1'b0}})) begin
        kill <= kill - CNT_ONE;
      end
    end
  end

  // Skid FIFO pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= {AW{1'b0}};
      wr_ptr     <= {AW{1'b0}};
      fifo_count <= {CW{1'b0}};
    end else if (redirect_valid) begin
      rd_ptr     <= {AW{1'b0}};
      wr_ptr     <= {AW{1'b0}};
      fifo_count <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Skid FIFO storage of {instruction, pc}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= 32'h0;
        fifo_pc[i]    <= {XLEN{1'b0}};
      end
    end else if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

  if_fetch_stage_checker #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .fifo_count (fifo_count),
    .inflight   (inflight),
    .pc_low     (pc[1:0])
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a simple in-order
// instruction memory model of configurable latency.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mem_lat = 1;

  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] issued[$];
  logic [63:0] dlv_pc[$];
  logic [31:0] dlv_instr[$];

  if_fetch_stage #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  // Memory content: each word is derived from its own address.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Memory model: responds in order, mem_lat cycles after accept.
  always @(negedge clk) begin
    cyc = cyc + 1;
    #2;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
        issued.push_back(imem_req_addr);
      end
    end
  end

  // Record every instruction accepted by decode.
  always @(negedge clk) begin
    #3;
    if (!reset && id_valid && id_ready) begin
      dlv_pc.push_back(id_pc);
      dlv_instr.push_back(id_instr);
    end
  end

  task automatic clear_logs();
    issued.delete();
    dlv_pc.delete();
    dlv_instr.delete();
  endtask

  // Returns at the negedge where reset is released (first fetch cycle).
  task automatic do_reset(input int lat);
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    id_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_lat = lat;
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
    total++; if (imem_req_addr !== 64'h0) begin bad++; $display("FAIL reset_req_addr got=%h want=0", imem_req_addr); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b want=0", id_valid); end
    total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL reset_id_instr got=%h want=0", id_instr); end
    total++; if (id_pc !== 64'h0) begin bad++; $display("FAIL reset_id_pc got=%h want=0", id_pc); end
  endtask

  task automatic test_sequential();
    do_reset(1);
    #4;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin bad++; $display("FAIL seq_c1_req got=%b/%h want=1/0", imem_req_valid, imem_req_addr); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL seq_c1_id_valid got=%b want=0", id_valid); end
    @(negedge clk); #4;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4) begin bad++; $display("FAIL seq_c2_req got=%b/%h want=1/4", imem_req_valid, imem_req_addr); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL seq_c2_id_valid got=%b want=0 (no bypass)", id_valid); end
    @(negedge clk); #4;
    total++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instr !== 32'hC0DE_0000) begin bad++; $display("FAIL seq_c3_head got=%b/%h/%h want=1/0/c0de0000", id_valid, id_pc, id_instr); end
    repeat (17) @(negedge clk);
    #4;
    total++; if (dlv_pc.size() < 8) begin bad++; $display("FAIL seq_count got=%0d want>=8", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== 64'(4*i) || dlv_instr[i] !== word_of(64'(4*i))) begin bad++; $display("FAIL seq_dlv[%0d] got=%h/%h want=%h/%h", i, dlv_pc[i], dlv_instr[i], 64'(4*i), word_of(64'(4*i))); end
    end
    for (int i = 0; i < issued.size(); i++) begin
      total++;
      if (issued[i] !== 64'(4*i)) begin bad++; $display("FAIL seq_issued[%0d] got=%h want=%h", i, issued[i], 64'(4*i)); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_head;
    do_reset(1);
    repeat (6) @(negedge clk);
    exp_head = 64'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      id_ready = 1'b0;
      #4;
      if (c == 0) begin
        if (dlv_pc.size() == 0) begin
          total++; bad++; $display("FAIL stall_pre_count got=0 want>0");
        end else begin
          exp_head = dlv_pc[dlv_pc.size()-1] + 64'h4;
        end
      end
      if (c >= 3) begin
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid[%0d] got=%b want=0", c, imem_req_valid); end
        total++; if (id_valid !== 1'b1 || id_pc !== exp_head || id_instr !== word_of(exp_head)) begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h want=1/%h/%h", c, id_valid, id_pc, id_instr, exp_head, word_of(exp_head)); end
      end
    end
    @(negedge clk);
    id_ready = 1'b1;
    repeat (12) @(negedge clk);
    #4;
    total++; if (dlv_pc.size() < 10) begin bad++; $display("FAIL stall_count got=%0d want>=10", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== 64'(4*i) || dlv_instr[i] !== word_of(64'(4*i))) begin bad++; $display("FAIL stall_dlv[%0d] got=%h/%h want=%h", i, dlv_pc[i], dlv_instr[i], 64'(4*i)); end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset(3);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h1002;
    #4;
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rdi_gate got=%b/%b want=0/0", id_valid, imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    total++; if (imem_req_addr !== 64'h1000) begin bad++; $display("FAIL rdi_addr got=%h want=1000", imem_req_addr); end
    repeat (20) @(negedge clk);
    #4;
    if (issued.size() < 4) begin
      total++; bad++; $display("FAIL rdi_issued_count got=%0d want>=4", issued.size());
    end else begin
      total++; if (issued[0] !== 64'h0 || issued[1] !== 64'h4 || issued[2] !== 64'h1000 || issued[3] !== 64'h1004) begin bad++; $display("FAIL rdi_issued got=%h,%h,%h,%h want=0,4,1000,1004", issued[0], issued[1], issued[2], issued[3]); end
    end
    total++; if (dlv_pc.size() < 4) begin bad++; $display("FAIL rdi_count got=%0d want>=4", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== 64'h1000 + 64'(4*i) || dlv_instr[i] !== word_of(64'h1000 + 64'(4*i))) begin bad++; $display("FAIL rdi_dlv[%0d] got=%h/%h want=%h", i, dlv_pc[i], dlv_instr[i], 64'h1000 + 64'(4*i)); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1);
    id_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    #4;
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rdf_gate got=%b/%b want=0/0", id_valid, imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    #4;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rdf_empty got=%b want=0", id_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin bad++; $display("FAIL rdf_req got=%b/%h want=1/2000", imem_req_valid, imem_req_addr); end
    repeat (10) @(negedge clk);
    #4;
    total++; if (dlv_pc.size() < 4) begin bad++; $display("FAIL rdf_count got=%0d want>=4", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== 64'h2000 + 64'(4*i) || dlv_instr[i] !== word_of(64'h2000 + 64'(4*i))) begin bad++; $display("FAIL rdf_dlv[%0d] got=%h/%h want=%h", i, dlv_pc[i], dlv_instr[i], 64'h2000 + 64'(4*i)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    repeat (5) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    clear_logs();
    #4;
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b/%b want=0/0", id_valid, imem_req_valid); end
    @(negedge clk);
    redirect_pc = 64'h300;
    #4;
    total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b/%b want=0/0", id_valid, imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (12) @(negedge clk);
    #4;
    if (issued.size() == 0) begin
      total++; bad++; $display("FAIL b2b_issued_count got=0 want>0");
    end else begin
      total++; if (issued[0] !== 64'h300) begin bad++; $display("FAIL b2b_issued0 got=%h want=300", issued[0]); end
    end
    total++; if (dlv_pc.size() < 4) begin bad++; $display("FAIL b2b_count got=%0d want>=4", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== 64'h300 + 64'(4*i) || dlv_instr[i] !== word_of(64'h300 + 64'(4*i))) begin bad++; $display("FAIL b2b_dlv[%0d] got=%h/%h want=%h", i, dlv_pc[i], dlv_instr[i], 64'h300 + 64'(4*i)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    repeat (6) @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #2;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h0) begin bad++; $display("FAIL ares_req got=%b/%h want=0/0", imem_req_valid, imem_req_addr); end
    total++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 64'h0) begin bad++; $display("FAIL ares_id got=%b/%h/%h want=0/0/0", id_valid, id_instr, id_pc); end
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b0;
    #4;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin bad++; $display("FAIL ares_restart got=%b/%h want=1/0", imem_req_valid, imem_req_addr); end
    repeat (10) @(negedge clk);
    #4;
    total++; if (dlv_pc.size() < 4) begin bad++; $display("FAIL ares_count got=%0d want>=4", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== 64'(4*i) || dlv_instr[i] !== word_of(64'(4*i))) begin bad++; $display("FAIL ares_dlv[%0d] got=%h/%h want=%h", i, dlv_pc[i], dlv_instr[i], 64'(4*i)); end
    end
  endtask

  task automatic test_pc_wrap();
    do_reset(1);
    repeat (4) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    total++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h want=fffffffffffffffc", imem_req_addr); end
    repeat (12) @(negedge clk);
    #4;
    if (issued.size() < 3) begin
      total++; bad++; $display("FAIL wrap_issued_count got=%0d want>=3", issued.size());
    end else begin
      total++; if (issued[0] !== 64'hFFFF_FFFF_FFFF_FFFC || issued[1] !== 64'h0 || issued[2] !== 64'h4) begin bad++; $display("FAIL wrap_issued got=%h,%h,%h want=fffffffffffffffc,0,4", issued[0], issued[1], issued[2]); end
    end
    if (dlv_pc.size() < 2) begin
      total++; bad++; $display("FAIL wrap_dlv_count got=%0d want>=2", dlv_pc.size());
    end else begin
      total++; if (dlv_pc[0] !== 64'hFFFF_FFFF_FFFF_FFFC || dlv_instr[0] !== 32'h3F21_FFFC) begin bad++; $display("FAIL wrap_dlv0 got=%h/%h want=fffffffffffffffc/3f21fffc", dlv_pc[0], dlv_instr[0]); end
      total++; if (dlv_pc[1] !== 64'h0 || dlv_instr[1] !== 32'hC0DE_0000) begin bad++; $display("FAIL wrap_dlv1 got=%h/%h want=0/c0de0000", dlv_pc[1], dlv_instr[1]); end
    end
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    id_ready       = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_full();
    test_back_to_back();
    test_async_reset();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
